// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - N-channel programmable seconds timer with one-shot/periodic modes
// Optional feature macro: TIMER_PAUSE_EN (adds per-channel pause input that freezes counting)
module timer_multi #(
    parameter int CLK_HZ = 10000,
    parameter int SEC_W  = 16,
    parameter int N_CH   = 4
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH-1:0]         periodic,
`ifdef TIMER_PAUSE_EN
    input  logic [N_CH-1:0]         pause,
`endif
    input  logic [N_CH*SEC_W-1:0]   secondsToCount,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH-1:0]         finished,
    output logic                    irq
);

    localparam int CYC_W = $clog2(CLK_HZ);
    localparam logic [CYC_W-1:0] CYC_MAX = CYC_W'(CLK_HZ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q [N_CH];
    state_e             state_d [N_CH];
    logic [CYC_W-1:0]   cyc_q   [N_CH];
    logic [CYC_W-1:0]   cyc_d   [N_CH];
    logic [SEC_W-1:0]   sec_q   [N_CH];
    logic [SEC_W-1:0]   sec_d   [N_CH];
    logic [SEC_W-1:0]   tgt_q   [N_CH];
    logic [SEC_W-1:0]   tgt_d   [N_CH];
    logic [N_CH-1:0]    mode_q;
    logic [N_CH-1:0]    mode_d;
    logic [N_CH-1:0]    finished_q;
    logic [N_CH-1:0]    finished_d;
    logic               irq_q;
    logic               irq_d;
    logic [N_CH-1:0]    hold;

`ifdef TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = '0;
`endif

    // Per-channel next-state: start (restart) beats stop, stop beats counting
    always_comb begin
        finished_d = '0;
        mode_d     = mode_q;
        irq_d      = |finished_q;
        for (int k = 0; k < N_CH; k++) begin
            state_d[k] = state_q[k];
            cyc_d[k]   = cyc_q[k];
            sec_d[k]   = sec_q[k];
            tgt_d[k]   = tgt_q[k];
            if (start[k]) begin
                // Restart drops any expiry that would have landed on this edge
                state_d[k] = RUN;
                tgt_d[k]   = secondsToCount[k*SEC_W +: SEC_W];
                mode_d[k]  = periodic[k];
                cyc_d[k]   = '0;
                sec_d[k]   = '0;
            end else if (state_q[k] == RUN) begin
                if (stop[k]) begin
                    state_d[k] = IDLE;
                end else if (!hold[k]) begin
                    // A zero target expires on every running edge; otherwise expiry is
                    // the edge that completes the last second (sec never passes tgt)
                    if ((tgt_q[k] == '0) ||
                        ((cyc_q[k] == CYC_MAX) && (sec_q[k] == tgt_q[k] - 1'b1))) begin
                        finished_d[k] = 1'b1;
                        cyc_d[k]      = '0;
                        sec_d[k]      = '0;
                        if (!mode_q[k]) begin
                            state_d[k] = IDLE;
                        end
                    end else if (cyc_q[k] == CYC_MAX) begin
                        cyc_d[k] = '0;
                        sec_d[k] = sec_q[k] + 1'b1;
                    end else begin
                        cyc_d[k] = cyc_q[k] + 1'b1;
                    end
                end
            end
        end
    end

    // State and counter registers; reset aborts every channel without a pulse
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= IDLE;
                cyc_q[k]   <= '0;
                sec_q[k]   <= '0;
                tgt_q[k]   <= '0;
            end
            mode_q     <= '0;
            finished_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= state_d[k];
                cyc_q[k]   <= cyc_d[k];
                sec_q[k]   <= sec_d[k];
                tgt_q[k]   <= tgt_d[k];
            end
            mode_q     <= mode_d;
            finished_q <= finished_d;
            irq_q      <= irq_d;
        end
    end

    // Busy reflects the registered channel state directly
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            busy[k] = (state_q[k] == RUN);
        end
    end

    assign finished = finished_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - randomized + directed self-checking bench for timer_multi
module tb_timer_multi;

    localparam int CLK_HZ = 10;
    localparam int SEC_W  = 8;
    localparam int N_CH   = 2;

    logic                  CLK = 1'b0;
    logic                  reset;
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       stop;
    logic [N_CH-1:0]       periodic;
    logic [N_CH-1:0]       pause_in;
    logic [N_CH*SEC_W-1:0] secondsToCount;
    logic [N_CH-1:0]       busy;
    logic [N_CH-1:0]       finished;
    logic                  irq;

    always #5 CLK = ~CLK;

    timer_multi #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W), .N_CH(N_CH)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .periodic       (periodic),
`ifdef TIMER_PAUSE_EN
        .pause          (pause_in),
`endif
        .secondsToCount (secondsToCount),
        .busy           (busy),
        .finished       (finished),
        .irq            (irq)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: each running channel holds the number of counting edges left
    bit              m_run  [N_CH];
    bit              m_mode [N_CH];
    int              m_rem  [N_CH];
    int              m_reload [N_CH];
    logic [N_CH-1:0] m_fin = '0;
    logic            m_irq = 1'b0;
    int              edge_n = 0;
    int              fin0_q [$];
    int              fin1_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [N_CH-1:0] m_busy();
        logic [N_CH-1:0] b;
        for (int k = 0; k < N_CH; k++) b[k] = m_run[k];
        return b;
    endfunction

    task automatic model_edge();
        logic [N_CH-1:0] fin_n;
        logic            hold;
        int              t;
        fin_n = '0;
        if (reset) begin
            for (int k = 0; k < N_CH; k++) m_run[k] = 1'b0;
            m_fin = '0;
            m_irq = 1'b0;
            return;
        end
        for (int k = 0; k < N_CH; k++) begin
`ifdef TIMER_PAUSE_EN
            hold = pause_in[k];
`else
            hold = 1'b0;
`endif
            if (start[k]) begin
                t           = int'(secondsToCount[k*SEC_W +: SEC_W]);
                m_run[k]    = 1'b1;
                m_mode[k]   = periodic[k];
                m_reload[k] = (t == 0) ? 1 : t * CLK_HZ;
                m_rem[k]    = m_reload[k];
            end else if (m_run[k]) begin
                if (stop[k]) begin
                    m_run[k] = 1'b0;
                end else if (!hold) begin
                    m_rem[k] = m_rem[k] - 1;
                    if (m_rem[k] == 0) begin
                        fin_n[k] = 1'b1;
                        if (m_mode[k]) m_rem[k] = m_reload[k];
                        else           m_run[k] = 1'b0;
                    end
                end
            end
        end
        m_irq = |m_fin;
        m_fin = fin_n;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        edge_n++;
        @(negedge CLK);
        check_eq("busy", 32'(busy), 32'(m_busy()));
        check_eq("finished", 32'(finished), 32'(m_fin));
        check_eq("irq", 32'(irq), 32'(m_irq));
        if (finished[0] === 1'b1) fin0_q.push_back(edge_n);
        if (finished[1] === 1'b1) fin1_q.push_back(edge_n);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_tgt(input int k, input int v);
        secondsToCount[k*SEC_W +: SEC_W] = SEC_W'(v);
    endtask

    task automatic clear_q();
        fin0_q.delete();
        fin1_q.delete();
    endtask

    int s;

    initial begin
        reset = 1'b1; start = '0; stop = '0; periodic = '0; pause_in = '0;
        secondsToCount = '0;
        for (int k = 0; k < N_CH; k++) begin
            m_run[k] = 1'b0; m_mode[k] = 1'b0; m_rem[k] = 0; m_reload[k] = 1;
        end
        @(negedge CLK);
        ticks(3);
        reset = 1'b0;
        ticks(2);
        check_eq("reset_busy", 32'(busy), 32'h0);
        check_eq("reset_irq", 32'(irq), 32'h0);

        // One-shot tgt=3: single pulse exactly 30 edges after start
        clear_q();
        set_tgt(0, 3); periodic[0] = 1'b0; start[0] = 1'b1; s = edge_n + 1;
        tick(); start = '0;
        ticks(40);
        check_eq("oneshot_cnt", 32'(fin0_q.size()), 32'd1);
        if (fin0_q.size() > 0) check_eq("oneshot_at", 32'(fin0_q[0] - s), 32'd30);

        // Periodic tgt=2 on ch1, stopped after 45 edges: pulses at 20 and 40 only
        clear_q();
        set_tgt(1, 2); periodic[1] = 1'b1; start[1] = 1'b1; s = edge_n + 1;
        tick(); start = '0; set_tgt(1, 7);
        ticks(44);
        stop[1] = 1'b1; tick(); stop = '0;
        ticks(30);
        check_eq("periodic_cnt", 32'(fin1_q.size()), 32'd2);
        if (fin1_q.size() == 2) begin
            check_eq("periodic_p1", 32'(fin1_q[0] - s), 32'd20);
            check_eq("periodic_p2", 32'(fin1_q[1] - s), 32'd40);
        end

        // tgt=0 one-shot, then tgt=0 periodic for 5 edges
        clear_q();
        set_tgt(0, 0); periodic[0] = 1'b0; start[0] = 1'b1; s = edge_n + 1;
        tick(); start = '0;
        ticks(5);
        check_eq("zero_os_cnt", 32'(fin0_q.size()), 32'd1);
        if (fin0_q.size() > 0) check_eq("zero_os_at", 32'(fin0_q[0] - s), 32'd1);
        clear_q();
        periodic[0] = 1'b1; start[0] = 1'b1;
        tick(); start = '0;
        ticks(5);
        stop[0] = 1'b1; tick(); stop = '0;
        ticks(3);
        check_eq("zero_per_cnt", 32'(fin0_q.size()), 32'd5);

        // Restart at edge 25 with tgt=1: pulse at 35 only
        clear_q();
        set_tgt(0, 3); periodic[0] = 1'b0; start[0] = 1'b1; s = edge_n + 1;
        tick(); start = '0;
        ticks(24);
        set_tgt(0, 1); start[0] = 1'b1;
        tick(); start = '0;
        ticks(15);
        check_eq("restart_cnt", 32'(fin0_q.size()), 32'd1);
        if (fin0_q.size() > 0) check_eq("restart_at", 32'(fin0_q[0] - s), 32'd35);

        // Restart exactly on the would-be expiry edge suppresses that pulse
        clear_q();
        set_tgt(0, 1); start[0] = 1'b1;
        tick(); start = '0;
        ticks(9);
        start[0] = 1'b1; tick(); start = '0;
        ticks(3);
        check_eq("restart_coinc", 32'(fin0_q.size()), 32'd0);
        stop[0] = 1'b1; tick(); stop = '0;

        // Reset mid-run, then start+stop together
        clear_q();
        set_tgt(0, 2); start[0] = 1'b1;
        tick(); start = '0;
        ticks(14);
        reset = 1'b1; tick(); reset = 1'b0;
        check_eq("rst_busy", 32'(busy), 32'h0);
        ticks(30);
        check_eq("rst_cnt", 32'(fin0_q.size()), 32'd0);
        set_tgt(0, 1); periodic[0] = 1'b0; start[0] = 1'b1; stop[0] = 1'b1; s = edge_n + 1;
        tick(); start = '0; stop = '0;
        check_eq("ss_busy", 32'(busy[0]), 32'h1);
        ticks(12);
        check_eq("ss_cnt", 32'(fin0_q.size()), 32'd1);
        if (fin0_q.size() > 0) check_eq("ss_at", 32'(fin0_q[0] - s), 32'd10);

        // Max target on ch1 alongside periodic tgt=1 on ch0 (simultaneous expiry)
        clear_q();
        set_tgt(1, (1 << SEC_W) - 1); periodic[1] = 1'b0;
        set_tgt(0, 1); periodic[0] = 1'b1; start = 2'b11; s = edge_n + 1;
        tick(); start = '0;
        ticks(2560);
        check_eq("max_cnt", 32'(fin1_q.size()), 32'd1);
        if (fin1_q.size() > 0) check_eq("max_at", 32'(fin1_q[0] - s), 32'(((1 << SEC_W) - 1) * CLK_HZ));
        stop[0] = 1'b1; tick(); stop = '0;

`ifdef TIMER_PAUSE_EN
        // Pause for 4 edges stretches a 10-edge run to 14
        clear_q();
        set_tgt(0, 1); periodic[0] = 1'b0; start[0] = 1'b1; s = edge_n + 1;
        tick(); start = '0;
        ticks(2);
        pause_in[0] = 1'b1; ticks(4); pause_in[0] = 1'b0;
        ticks(12);
        check_eq("pause_cnt", 32'(fin0_q.size()), 32'd1);
        if (fin0_q.size() > 0) check_eq("pause_at", 32'(fin0_q[0] - s), 32'd14);
`endif

        // Random traffic checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 599) == 0);
            for (int k = 0; k < N_CH; k++) begin
                start[k]    = ($urandom_range(0, 44) == 0);
                stop[k]     = ($urandom_range(0, 69) == 0);
                periodic[k] = $urandom_range(0, 1) != 0;
                pause_in[k] = ($urandom_range(0, 7) == 0);
                set_tgt(k, ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
